// File: rtl/bit_gen_pipe.sv
// bit_gen_pipe: pipelined VGA pixel generator.
//   Takes the timing controller's bright/hPos/vPos and computes the frame-buffer
//   word address of the tile under the beam. It then picks one packed palette
//   index from the returned word and looks it up in a 16-entry RGB palette.
//   A three-colour top bar and a square mouse cursor are drawn over the image.
//   The fixed latency from input sample to RGB/bright_out is MEM_LAT+2 clocks.
// Ports:
//   clk, rst_n          pixel clock, asynchronous active-low reset
//   bright, hPos, vPos  beam state from the timing controller
//   x, y                cursor top-left corner
//   bufOut              frame-buffer read data (MEM_LAT cycles after address)
//   pal_we/idx/data     palette write port ({R,G,B})
//   address             registered frame-buffer read address
//   red/green/blue      registered colour outputs
//   bright_out          bright, delayed to line up with RGB
module bit_gen_pipe #(
  parameter int TILE_SHIFT   = 3,
  parameter int PIX_BITS     = 4,
  parameter int PIX_PER_WORD = 4,
  parameter int WORD_W       = 16,
  parameter int ROW_WORDS    = 20,
  parameter int ADDR_STRIDE  = 16,
  parameter int BASE_ADDR    = 16384,
  parameter int MEM_LAT      = 1,
  parameter int TOP_H        = 80,
  parameter int BAR_SPLIT1   = 214,
  parameter int BAR_SPLIT2   = 427,
  parameter int CUR_SIZE     = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                bright,
  input  logic [9:0]          hPos,
  input  logic [8:0]          vPos,
  input  logic [9:0]          x,
  input  logic [8:0]          y,
  input  logic [WORD_W-1:0]   bufOut,
  input  logic                pal_we,
  input  logic [PIX_BITS-1:0] pal_idx,
  input  logic [23:0]         pal_data,
  output logic [15:0]         address,
  output logic [7:0]          red,
  output logic [7:0]          green,
  output logic [7:0]          blue,
  output logic                bright_out
);

  localparam int WSH    = $clog2(PIX_PER_WORD);
  localparam int SLOT_W = (WSH < 1) ? 1 : WSH;

  // BLANK must encode as zero: clearing the delay line then yields black pixels.
  typedef enum logic [2:0] {
    BLANK    = 3'd0,
    CUR_EDGE = 3'd1,
    CUR_FILL = 3'd2,
    FB       = 3'd3,
    BAR_R    = 3'd4,
    BAR_G    = 3'd5,
    BAR_B    = 3'd6
  } region_e;

  typedef struct packed {
    logic              bright;
    region_e           region;
    logic [SLOT_W-1:0] slot;
  } side_t;

  // ---------------- stage 1: address, slot, region ----------------
  logic [15:0] address_q, address_d;
  side_t       side_d;
  side_t       side_q [MEM_LAT:0];

  logic [10:0] h11, cx_end;
  logic [9:0]  v10, cy_end;
  logic        in_sq, on_ring, is_fb;
  logic [31:0] col_w, row_w;

  // The cursor extents are computed one bit wider than the positions.
  // A cursor near the right or bottom edge is therefore clipped and never
  // wraps to column or row 0.
  assign h11    = {1'b0, hPos};
  assign v10    = {1'b0, vPos};
  assign cx_end = {1'b0, x} + 11'(CUR_SIZE - 1);
  assign cy_end = {1'b0, y} + 10'(CUR_SIZE - 1);
  assign in_sq  = (h11 >= {1'b0, x}) && (h11 <= cx_end) &&
                  (v10 >= {1'b0, y}) && (v10 <= cy_end);
  assign on_ring = (hPos == x) || (h11 == cx_end) || (vPos == y) || (v10 == cy_end);
  assign is_fb  = (32'(vPos) >= 32'(TOP_H));

  assign col_w = 32'(hPos) >> (TILE_SHIFT + WSH);
  assign row_w = (32'(vPos) - 32'(TOP_H)) >> TILE_SHIFT;

  always_comb begin
    address_d = address_q;
    if (is_fb)
      address_d = 16'(32'(BASE_ADDR) + (col_w + row_w * 32'(ROW_WORDS)) * 32'(ADDR_STRIDE));
  end

  always_comb begin
    side_d        = '0;
    side_d.bright = bright;
    side_d.slot   = (PIX_PER_WORD == 1) ? '0 : SLOT_W'(hPos >> TILE_SHIFT);
    if (!bright)                       side_d.region = BLANK;
    else if (in_sq && on_ring)         side_d.region = CUR_EDGE;
    else if (in_sq)                    side_d.region = CUR_FILL;
    else if (is_fb)                    side_d.region = FB;
    else if (32'(hPos) < BAR_SPLIT1)   side_d.region = BAR_R;
    else if (32'(hPos) < BAR_SPLIT2)   side_d.region = BAR_G;
    else                               side_d.region = BAR_B;
  end

  // side_q[0] is the stage-1 register. side_q[MEM_LAT] lines up with bufOut.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      address_q <= '0;
      for (int i = 0; i <= MEM_LAT; i++) side_q[i] <= '0;
    end else begin
      address_q <= address_d;
      side_q[0] <= side_d;
      for (int i = 1; i <= MEM_LAT; i++) side_q[i] <= side_q[i-1];
    end
  end

  // ---------------- palette ----------------
  logic [23:0] pal_q [16];
  logic [3:0]  wr_idx;

  // Only 16 entries exist. A wider index aliases modulo 16.
  assign wr_idx = 4'(pal_idx);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) pal_q[i] <= 24'h000000;
      pal_q[0] <= 24'hFFFFFF;
      pal_q[1] <= 24'hFF0000;
      pal_q[2] <= 24'h00FF00;
      pal_q[4] <= 24'h0000FF;
    end else if (pal_we) begin
      pal_q[wr_idx] <= pal_data;
    end
  end

  // ---------------- output stage ----------------
  side_t       side_o;
  logic [3:0]  rd_idx;
  logic [23:0] rgb_d, rgb_q;
  logic        bright_q;

  assign side_o = side_q[MEM_LAT];
  assign rd_idx = 4'(bufOut[side_o.slot * PIX_BITS +: PIX_BITS]);

  // The palette is read from the register array here. A write landing on the
  // same edge therefore returns the old entry, and the new one is seen a cycle later.
  always_comb begin
    rgb_d = 24'h000000;
    case (side_o.region)
      FB:       rgb_d = pal_q[rd_idx];
      CUR_FILL: rgb_d = 24'hFFFFFF;
      BAR_R:    rgb_d = 24'hFF0000;
      BAR_G:    rgb_d = 24'h00FF00;
      BAR_B:    rgb_d = 24'h0000FF;
      default:  rgb_d = 24'h000000;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rgb_q    <= '0;
      bright_q <= 1'b0;
    end else begin
      rgb_q    <= rgb_d;
      bright_q <= side_o.bright;
    end
  end

  assign address    = address_q;
  assign red        = rgb_q[23:16];
  assign green      = rgb_q[15:8];
  assign blue       = rgb_q[7:0];
  assign bright_out = bright_q;

endmodule

// File: tb/tb_bit_gen_pipe.sv
// Directed bench for bit_gen_pipe with the default parameters (MEM_LAT=1 -> 3-cycle latency).
module tb_bit_gen_pipe;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        bright = 1'b0;
  logic [9:0]  hPos = '0;
  logic [8:0]  vPos = '0;
  logic [9:0]  x = 10'd1000;
  logic [8:0]  y = 9'd500;
  logic [15:0] bufOut = '0;
  logic        pal_we = 1'b0;
  logic [3:0]  pal_idx = '0;
  logic [23:0] pal_data = '0;
  logic [15:0] address;
  logic [7:0]  red, green, blue;
  logic        bright_out;
  logic [23:0] rgb;

  int checks = 0;
  int failures = 0;

  bit_gen_pipe dut (
    .clk(clk), .rst_n(rst_n), .bright(bright), .hPos(hPos), .vPos(vPos),
    .x(x), .y(y), .bufOut(bufOut), .pal_we(pal_we), .pal_idx(pal_idx),
    .pal_data(pal_data), .address(address), .red(red), .green(green),
    .blue(blue), .bright_out(bright_out)
  );

  always #5 clk = ~clk;
  assign rgb = {red, green, blue};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Presents one pixel, holds it, and checks the output three edges later.
  task automatic pix(input string tag, input logic b, input logic [9:0] h,
                     input logic [8:0] v, input logic [15:0] w, input logic [23:0] exp);
    bright = b; hPos = h; vPos = v; bufOut = w;
    repeat (3) @(posedge clk);
    #1;
    chk({tag, "_rgb"}, 32'(rgb), 32'(exp));
    chk({tag, "_bo"}, 32'(bright_out), 32'(b));
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_rgb", 32'(rgb), 32'h0);
    chk("rst_bo", 32'(bright_out), 32'h0);
    chk("rst_addr", 32'(address), 32'h0);
    rst_n = 1'b1;

    // address one edge after the input is sampled
    bright = 1'b1; hPos = 10'd100; vPos = 9'd95; bufOut = 16'h0421;
    @(posedge clk); #1;
    chk("addr_100_95", 32'(address), 32'd16752);
    pix("fb_slot0", 1'b1, 10'd100, 9'd95, 16'h0421, 24'hFF0000);
    pix("fb_slot3_blue", 1'b1, 10'd120, 9'd95, 16'h4000, 24'h0000FF);
    pix("fb_slot3_white", 1'b1, 10'd120, 9'd95, 16'h0421, 24'hFFFFFF);
    pix("fb_idx2", 1'b1, 10'd100, 9'd95, 16'h0002, 24'h00FF00);
    pix("fb_idx5", 1'b1, 10'd100, 9'd95, 16'h0005, 24'h000000);

    // palette write, then a later read
    pal_we = 1'b1; pal_idx = 4'd3; pal_data = 24'h123456;
    @(posedge clk); #1;
    pal_we = 1'b0;
    pix("pal_write", 1'b1, 10'd100, 9'd95, 16'h0003, 24'h123456);

    // A write on the same edge as the output-stage read returns the old entry.
    bright = 1'b1; hPos = 10'd100; vPos = 9'd95; bufOut = 16'h0003;
    repeat (2) @(posedge clk);
    #1;
    pal_we = 1'b1; pal_idx = 4'd3; pal_data = 24'hABCDEF;
    @(posedge clk); #1;
    pal_we = 1'b0;
    chk("pal_same_cycle", 32'(rgb), 32'h123456);
    pix("pal_new", 1'b1, 10'd100, 9'd95, 16'h0003, 24'hABCDEF);

    // cursor
    x = 10'd200; y = 9'd200;
    pix("cur_corner", 1'b1, 10'd200, 9'd200, 16'h0421, 24'h000000);
    pix("cur_fill", 1'b1, 10'd203, 9'd203, 16'h0421, 24'hFFFFFF);
    pix("cur_far_corner", 1'b1, 10'd207, 9'd207, 16'h0421, 24'h000000);
    pix("cur_right_out", 1'b1, 10'd208, 9'd203, 16'h0421, 24'h0000FF);
    chk("addr_208_203", 32'(address), 32'd21280);

    // The cursor is clipped at the right and bottom edges and never wraps.
    x = 10'd1020; y = 9'd200;
    pix("cur_no_xwrap", 1'b1, 10'd2, 9'd203, 16'h0421, 24'hFF0000);
    x = 10'd200; y = 9'd510;
    pix("cur_no_ywrap", 1'b1, 10'd203, 9'd3, 16'h0421, 24'hFF0000);
    x = 10'd1000; y = 9'd500;

    // top bar; address must hold from the last FB pixel (21280 -> set again)
    pix("fb_reload", 1'b1, 10'd208, 9'd203, 16'h0421, 24'h0000FF);
    pix("bar_213", 1'b1, 10'd213, 9'd10, 16'h0421, 24'hFF0000);
    pix("bar_214", 1'b1, 10'd214, 9'd10, 16'h0421, 24'h00FF00);
    pix("bar_426", 1'b1, 10'd426, 9'd10, 16'h0421, 24'h00FF00);
    pix("bar_427", 1'b1, 10'd427, 9'd10, 16'h0421, 24'h0000FF);
    pix("blank", 1'b0, 10'd300, 9'd10, 16'h0421, 24'h000000);
    pix("blank_fb", 1'b0, 10'd100, 9'd95, 16'h0421, 24'h000000);
    chk("addr_blank_fb", 32'(address), 32'd16752);
    pix("bar_hold", 1'b1, 10'd50, 9'd79, 16'h0421, 24'hFF0000);
    chk("addr_hold", 32'(address), 32'd16752);

    // asynchronous reset mid-line
    pix("pre_rst", 1'b1, 10'd100, 9'd95, 16'h0003, 24'hABCDEF);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_rgb", 32'(rgb), 32'h0);
    chk("async_rst_bo", 32'(bright_out), 32'h0);
    chk("async_rst_addr", 32'(address), 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    pix("post_rst_pal1", 1'b1, 10'd100, 9'd95, 16'h0001, 24'hFF0000);
    pix("post_rst_pal3", 1'b1, 10'd100, 9'd95, 16'h0003, 24'h000000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
